// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory port controller.
package dmem_pkg;

    // Transaction state: idle, request outstanding on the bus, completion cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dm_state_e;

    // access_size encodings; 2'b11 is reserved and handled as a word.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/dmem_lane_gen.sv
// Big-endian byte-lane generator: byte enables, replicated store data and
// store-misalignment detection from the low address bits and access size.
module dmem_lane_gen
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        write,
    input  logic [31:0] wdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign
);

    // Reads always fetch the full word; stores enable only the addressed lanes.
    always_comb begin
        be       = 4'b1111;
        wdata    = 32'h0;
        misalign = 1'b0;
        if (write) begin
            unique case (size)
                SZ_BYTE: begin
                    // be[3] is byte offset 0, so the lane walks downward.
                    be    = 4'b1000 >> addr_lo;
                    wdata = {4{wdata_in[7:0]}};
                end
                SZ_HALF: begin
                    be       = addr_lo[1] ? 4'b0011 : 4'b1100;
                    wdata    = {2{wdata_in[15:0]}};
                    misalign = addr_lo[0];
                end
                default: begin
                    // SZ_WORD and the reserved code.
                    be       = 4'b1111;
                    wdata    = wdata_in;
                    misalign = |addr_lo;
                end
            endcase
        end
    end

endmodule

// File: rtl/dmem_port.sv
// Data-memory port controller: turns a MEM-stage read/write request into one
// handshaked word-aligned bus transaction, stalling the pipeline until done.
module dmem_port
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MemRead_2DM,
    input  logic        MemWrite_2DM,
    input  logic [31:0] data_address_2DM,
    input  logic [31:0] data_write_2DM,
    input  logic [1:0]  access_size,
    output logic [31:0] data_read_fDM,
    output logic        Stall_DM,
    output logic        dm_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    // Last REQ cycle count value before giving up.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    dm_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        flt_q, flt_d;
    logic [31:0] data_q, data_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic        lane_misalign;
    logic        request, req_bad, launch;

    dmem_lane_gen u_lane_gen (
        .addr_lo  (data_address_2DM[1:0]),
        .size     (access_size),
        .write    (MemWrite_2DM),
        .wdata_in (data_write_2DM),
        .be       (lane_be),
        .wdata    (lane_wdata),
        .misalign (lane_misalign)
    );

    assign request = MemRead_2DM | MemWrite_2DM;
    assign req_bad = (MemRead_2DM & MemWrite_2DM) | lane_misalign;
    assign launch  = (state_q == IDLE) && request && !req_bad;

    // State, timeout counter, fault flag and bus/read-data registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= 8'h0;
            flt_q   <= 1'b0;
            data_q  <= 32'h0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flt_q   <= flt_d;
            data_q  <= data_d;
            if (launch) begin
                we_q    <= MemWrite_2DM;
                addr_q  <= {data_address_2DM[31:2], 2'b00};
                be_q    <= lane_be;
                wdata_q <= lane_wdata;
            end
        end
    end

    // Next state: launch from IDLE, leave REQ on ack or timeout, DONE always returns.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flt_d   = flt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = REQ;
                    cnt_d   = 8'h0;
                    flt_d   = 1'b0;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    state_d = DONE;
                    flt_d   = bus_err;
                    if (!we_q) data_d = bus_err ? 32'h0 : bus_rdata;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = DONE;
                    flt_d   = 1'b1;
                    if (!we_q) data_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 8'h1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: stall covers the launch cycle and REQ; faults pulse in IDLE or DONE.
    always_comb begin
        Stall_DM = 1'b0;
        dm_fault = 1'b0;
        bus_req  = 1'b0;
        case (state_q)
            IDLE: begin
                if (request) begin
                    if (req_bad) dm_fault = 1'b1;
                    else         Stall_DM = 1'b1;
                end
            end
            REQ: begin
                bus_req  = 1'b1;
                Stall_DM = 1'b1;
            end
            DONE:    dm_fault = flt_q;
            default: ;
        endcase
    end

    assign data_read_fDM = data_q;
    assign bus_we        = we_q;
    assign bus_addr      = addr_q;
    assign bus_be        = be_q;
    assign bus_wdata     = wdata_q;

endmodule

// File: tb/tb_dmem_port.sv
// Scoreboard bench for dmem_port: the driver pushes the expected outcome of each
// operation, a bus responder answers requests, a monitor checks each completion.
module tb_dmem_port;

    localparam int TMO = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        MemRead_2DM = 1'b0;
    logic        MemWrite_2DM = 1'b0;
    logic [31:0] data_address_2DM = 32'h0;
    logic [31:0] data_write_2DM = 32'h0;
    logic [1:0]  access_size = 2'b00;
    logic [31:0] data_read_fDM;
    logic        Stall_DM;
    logic        dm_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    dmem_port #(.TIMEOUT(TMO)) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .MemRead_2DM      (MemRead_2DM),
        .MemWrite_2DM     (MemWrite_2DM),
        .data_address_2DM (data_address_2DM),
        .data_write_2DM   (data_write_2DM),
        .access_size      (access_size),
        .data_read_fDM    (data_read_fDM),
        .Stall_DM         (Stall_DM),
        .dm_fault         (dm_fault),
        .bus_req          (bus_req),
        .bus_we           (bus_we),
        .bus_addr         (bus_addr),
        .bus_be           (bus_be),
        .bus_wdata        (bus_wdata),
        .bus_ack          (bus_ack),
        .bus_err          (bus_err),
        .bus_rdata        (bus_rdata)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        fault;
        int          stall;
        logic [31:0] data;
        logic        bus;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_data = 32'h0;
    int          plan_k = 0;
    logic [31:0] plan_rdata = 32'h0;
    logic        plan_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Bus responder: acks the planned REQ cycle; outside REQ drives random noise.
    int req_cyc = 0;
    always @(posedge CLK) begin
        #1;
        if (bus_req) begin
            bus_ack   = (req_cyc == plan_k);
            bus_err   = (req_cyc == plan_k) && plan_err;
            bus_rdata = plan_rdata;
            req_cyc++;
        end else begin
            req_cyc   = 0;
            bus_ack   = ($urandom_range(0, 3) == 0);
            bus_err   = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
        end
    end

    // Monitor: track stall length and bus request, check at each completion.
    logic        in_req = 1'b0;
    logic        unstable = 1'b0;
    int          stall_cnt = 0;
    int          starts = 0;
    logic        c_we;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    always @(negedge CLK) begin
        if (RESET) begin
            in_req = 1'b0; stall_cnt = 0; starts = 0; unstable = 1'b0;
        end else begin
            if (bus_req) begin
                if (!in_req) begin
                    starts++;
                    c_we = bus_we; c_addr = bus_addr; c_be = bus_be; c_wdata = bus_wdata;
                end else if ({bus_we, bus_addr, bus_be, bus_wdata} !== {c_we, c_addr, c_be, c_wdata})
                    unstable = 1'b1;
            end
            in_req = bus_req;
            if (Stall_DM) begin
                stall_cnt++;
            end else if (stall_cnt > 0 || dm_fault) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_completion: got stall %0d fault %0b, expected none",
                             stall_cnt, dm_fault);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("fault", 32'(dm_fault), 32'(mon_e.fault));
                    chk("stall_len", stall_cnt, mon_e.stall);
                    chk("read_data", data_read_fDM, mon_e.data);
                    chk("bus_req_count", starts, mon_e.bus ? 1 : 0);
                    chk("bus_req_after", 32'(bus_req), 32'h0);
                    if (mon_e.bus) begin
                        chk("bus_we", 32'(c_we), 32'(mon_e.we));
                        chk("bus_addr", c_addr, mon_e.addr);
                        chk("bus_be", 32'(c_be), 32'(mon_e.be));
                        if (mon_e.we) chk("bus_wdata", c_wdata, mon_e.wdata);
                        chk("bus_stable", 32'(unstable), 32'h0);
                    end
                end
                stall_cnt = 0; starts = 0; unstable = 1'b0;
            end
        end
    end

    // Issue one operation at posedge+1; returns at posedge+1 of the following IDLE cycle.
    task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] d, input logic [1:0] sz, input int k,
                         input logic [31:0] rdata, input bit err);
        exp_t e;
        int   lane;
        int   n;
        bit   bad;
        lane = int'(addr[1:0]);
        bad  = (rd && wr) || (wr && ((sz == 2'd1 && lane % 2 == 1) || (sz >= 2'd2 && lane != 0)));
        e.we = wr; e.be = 4'h0; e.wdata = 32'h0; e.addr = 32'h0;
        if (bad) begin
            e.fault = 1'b1; e.stall = 0; e.bus = 1'b0;
        end else begin
            e.bus  = 1'b1;
            e.addr = addr & 32'hFFFF_FFFC;
            if (!wr) begin
                e.be = 4'hF;
            end else if (sz == 2'd0) begin
                e.be = 4'(8 >> lane); e.wdata = {24'h0, d[7:0]} * 32'h0101_0101;
            end else if (sz == 2'd1) begin
                e.be = (lane < 2) ? 4'hC : 4'h3; e.wdata = {16'h0, d[15:0]} * 32'h0001_0001;
            end else begin
                e.be = 4'hF; e.wdata = d;
            end
            if (k < TMO) begin
                e.stall = 2 + k; e.fault = err;
                if (rd) model_data = err ? 32'h0 : rdata;
            end else begin
                e.stall = 1 + TMO; e.fault = 1'b1;
                if (rd) model_data = 32'h0;
            end
        end
        e.data = model_data;
        exp_q.push_back(e);
        plan_k = k; plan_rdata = rdata; plan_err = err;
        MemRead_2DM = rd; MemWrite_2DM = wr;
        data_address_2DM = addr; data_write_2DM = d; access_size = sz;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (Stall_DM && n < 200);
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL op_stall_bound: got stall beyond 200 cycles, expected release");
        end
        @(posedge CLK); #1;
        MemRead_2DM = 1'b0; MemWrite_2DM = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_bus_req"}, 32'(bus_req), 32'h0);
        chk({tag, "_stall"}, 32'(Stall_DM), 32'h0);
        chk({tag, "_fault"}, 32'(dm_fault), 32'h0);
        chk({tag, "_we"}, 32'(bus_we), 32'h0);
        chk({tag, "_addr"}, bus_addr, 32'h0);
        chk({tag, "_be"}, 32'(bus_be), 32'h0);
        chk({tag, "_wdata"}, bus_wdata, 32'h0);
        chk({tag, "_rdata"}, data_read_fDM, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          rd, wr;
        logic [1:0]  sz;
        logic [31:0] a;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RESET = 1'b0;
        @(posedge CLK); #1;

        // Directed cases.
        do_op(1, 0, 32'h104, 32'h0, 2'd2, 0, 32'hDEAD_BEEF, 0);
        do_op(0, 1, 32'h203, 32'h0000_00A5, 2'd0, 3, 32'h1111_1111, 0);
        do_op(0, 1, 32'h201, 32'h0000_BEEF, 2'd1, 0, 32'h0, 0);
        do_op(1, 1, 32'h300, 32'h0, 2'd2, 0, 32'h0, 0);
        do_op(1, 0, 32'h400, 32'h0, 2'd2, 1000, 32'hCAFE_F00D, 0);
        do_op(1, 0, 32'h500, 32'h0, 2'd2, 1, 32'h1234_5678, 0);
        do_op(1, 0, 32'h504, 32'h0, 2'd2, 0, 32'h5555_AAAA, 1);
        do_op(1, 0, 32'h600, 32'h0, 2'd2, 0, 32'hA1A2_A3A4, 0);
        do_op(1, 0, 32'h604, 32'h0, 2'd2, TMO - 1, 32'hB1B2_B3B4, 0);
        do_op(0, 1, 32'h702, 32'h1234_C0DE, 2'd1, 2, 32'h0, 0);
        do_op(0, 1, 32'h708, 32'h0BAD_F00D, 2'd3, 0, 32'h0, 0);

        // Random traffic with occasional idle gaps.
        for (int i = 0; i < 250; i++) begin
            rd = ($urandom_range(0, 1) == 1);
            wr = !rd || ($urandom_range(0, 9) == 0);
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                else if (sz != 2'd0) a[1:0] = 2'b00;
            end
            do_op(rd, wr, a, $urandom, sz, $urandom_range(0, TMO + 1), $urandom,
                  ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge CLK); #1;
                end
            end
        end

        // Reset during REQ: make read data nonzero first so its clear is visible.
        do_op(1, 0, 32'h800, 32'h0, 2'd2, 0, 32'h7777_1234, 0);
        plan_k = 1000;
        MemRead_2DM = 1'b1; data_address_2DM = 32'h900; access_size = 2'd2;
        repeat (3) @(negedge CLK);
        chk("req_before_reset", 32'(bus_req), 32'h1);
        #1;
        RESET = 1'b1; MemRead_2DM = 1'b0;
        exp_q.delete();
        model_data = 32'h0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK); #1;
        do_op(1, 0, 32'hA00, 32'h0, 2'd2, TMO - 1, 32'h0F0F_0F0F, 0);
        do_op(1, 0, 32'hA04, 32'h0, 2'd2, TMO, 32'h0F0F_0F0F, 0);

        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_port.md
# dmem_port

Data-memory port controller between the MEM stage and the external data-memory bus. It turns MEM's per-instruction read/write request into one handshaked, word-aligned bus transaction with big-endian byte enables. It stalls the pipeline until the bus acknowledges, then returns the read word that the MEM stage aligns for LB/LH/LBU/LHU/LWL/LWR. Misaligned stores, bus errors and timeouts are reported as a one-cycle fault.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles in REQ without `bus_ack` before a fault; range 1..255; counter is 8 bits.

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-high
- MemRead_2DM  in  1  read request from MEM stage
- MemWrite_2DM  in  1  write request from MEM stage
- data_address_2DM  in  32  byte address
- data_write_2DM  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- access_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- data_read_fDM  out  32  last read word, big-endian, word-aligned
- Stall_DM  out  1  freeze pipeline (combinational)
- dm_fault  out  1  one-cycle fault pulse
- bus_req  out  1  transaction request
- bus_we  out  1  1 = write
- bus_addr  out  32  {data_address_2DM[31:2], 2'b00}
- bus_be  out  4  byte enables; be[3] = bits 31:24 = byte offset 0
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  transaction complete
- bus_err  in  1  transaction failed; valid only with `bus_ack`
- bus_rdata  in  32  read data; valid with `bus_ack`

## Operation
- **States:** IDLE, REQ, DONE. Reset forces IDLE.
- **IDLE**, request = MemRead_2DM | MemWrite_2DM:
  - Both read and write asserted, or a misaligned store: `dm_fault` = 1 for this cycle. No bus access, no stall, stay in IDLE.
  - Misaligned store means half with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - Otherwise go to REQ. `Stall_DM` = 1 in this same cycle.
- **REQ:**
  - `bus_req` = 1 and `Stall_DM` = 1.
  - `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` are registered at IDLE→REQ and held stable until ack.
  - On `bus_ack`: go to DONE. On a read, capture `bus_rdata` into `data_read_fDM`, or 0 if `bus_err`.
  - Timeout counter increments each REQ cycle. At TIMEOUT without ack: go to DONE and set the fault flag. A read returns 0.
- **DONE:**
  - `Stall_DM` = 0 and `bus_req` = 0, so the pipeline advances at the end of this cycle.
  - `dm_fault` = 1 if `bus_err` or timeout occurred.
  - Next state is always IDLE; the still-present old request is not relaunched.
- **Lanes (big-endian):**
  - Read: `bus_be` = 1111; the full word is returned.
  - Byte store: `bus_be` = 1000 >> addr[1:0], `bus_wdata` = {4{d[7:0]}}.
  - Half store: `bus_be` = 1100 (addr[1] = 0) or 0011 (addr[1] = 1), `bus_wdata` = {2{d[15:0]}}.
  - Word store: `bus_be` = 1111, `bus_wdata` = d.
- `data_read_fDM` holds its value until the next completed read; writes do not change it.

## Timing
- **Reset values:** `data_read_fDM` = 0, `Stall_DM` = 0 (no request), `dm_fault` = 0, `bus_req` = 0, `bus_we` = 0, `bus_addr` = 0, `bus_be` = 0, `bus_wdata` = 0, timeout counter = 0.
- **Minimum latency** with ack in the first REQ cycle: IDLE, REQ, DONE = 3 cycles; the pipeline is stalled for 2 of them.
- **Ack k cycles after REQ entry** (ack in the first cycle is k = 0): stall length = 2 + k.
- **RESET asserted mid-transaction:** `bus_req` drops immediately (asynchronous), the FSM returns to IDLE and the counter clears. No fault is reported.
- `bus_ack` outside REQ is ignored.
- The counter clears on every REQ entry.

## Structure
- Package `dmem_pkg`: state enum (IDLE/REQ/DONE), size codes SZ_BYTE/SZ_HALF/SZ_WORD, default TIMEOUT constant.
- Sub-module `dmem_lane_gen` (combinational): maps address, size and write flag to `bus_be`, `bus_wdata` and a misalign flag.
- Top contains the FSM, the timeout counter and the output registers.

## Test plan
- **Read, zero-wait:** MemRead, addr 0x104, ack with rdata 0xDEADBEEF in the first REQ cycle -> Stall_DM 1 for 2 cycles, bus_addr 0x104, be 1111, data_read_fDM = 0xDEADBEEF in DONE.
- **Byte store:** addr 0x203, d = 0x000000A5, ack after 3 wait cycles -> be 0001, wdata 0xA5A5A5A5, stall 5 cycles, data_read_fDM unchanged.
- **Misaligned store and read+write:** half store to 0x201 -> dm_fault pulse, no bus_req, no stall. Read and write both asserted -> the same.
- **Timeout and bus error:** TIMEOUT = 4, no ack -> DONE after 4 REQ cycles, dm_fault 1, data_read_fDM = 0. Read acked with bus_err -> fault, data 0.
- **Back-to-back and reset:** two consecutive reads -> the second launches only in the IDLE cycle after DONE, with no duplicate request. RESET asserted in REQ -> bus_req 0 immediately, all outputs at their reset values.
